// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the parametrised SPI master.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_e;

   typedef struct packed {
      logic ckp;
      logic cph;
   } mode_t;

   localparam int DEF_WIDTH      = 16;
   localparam int DEF_EDGE_CNT_W = $clog2(2 * DEF_WIDTH);

   function automatic int edge_cnt_w(input int width);
      return $clog2(2 * width);
   endfunction

   // One code point beyond the last slave must be expressible so it can be rejected.
   function automatic int cs_sel_w(input int num_cs);
      return $clog2(num_cs + 1);
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK timebase: DIV prescaler, SCK edge counter and leading/trailing strobes.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIV   = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   input  logic shift_i,
   input  logic idle_lvl_i,
   output logic tick_o,
   output logic lead_stb_o,
   output logic trail_stb_o,
   output logic last_o,
   output logic sck_o
);

   localparam int EW  = edge_cnt_w(WIDTH);
   localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [DCW-1:0] cnt_q, cnt_d;
   logic [EW-1:0]  edge_q, edge_d;
   logic           sck_q, sck_d;
   logic           tick_s;

   assign tick_s = run_i && (cnt_q == DCW'(DIV - 1));

   // Prescaler wraps every DIV cycles; SCK is parked at the idle level outside SHIFT.
   always_comb begin
      cnt_d  = cnt_q;
      edge_d = edge_q;
      sck_d  = sck_q;
      if (!run_i || tick_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DCW'(1);
      end
      if (!shift_i) begin
         edge_d = '0;
         sck_d  = idle_lvl_i;
      end else if (tick_s) begin
         edge_d = edge_q + EW'(1);
         sck_d  = ~sck_q;
      end else begin
         edge_d = edge_q;
      end
   end

   // Timebase state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         edge_q <= '0;
         sck_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         edge_q <= edge_d;
         sck_q  <= sck_d;
      end
   end

   assign tick_o      = tick_s;
   assign lead_stb_o  = shift_i && tick_s && !edge_q[0];
   assign trail_stb_o = shift_i && tick_s && edge_q[0];
   assign last_o      = (edge_q == EW'(2 * WIDTH - 1));
   assign sck_o       = sck_q;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master with START/DONE handshake and all four CKP/CPH modes.
// Optional internal MOSI->sample loopback port when SPI_LOOPBACK_EN is defined.
module spi_master_param
   import spi_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int NUM_CS = 4,
   parameter int DIV    = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          enb_i,
   input  logic                          ckp_i,
   input  logic                          cph_i,
   input  logic                          start_i,
   input  logic [cs_sel_w(NUM_CS)-1:0]   cs_sel_i,
   input  logic [WIDTH-1:0]              tx_data_i,
   output logic [WIDTH-1:0]              rx_data_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          sck_o,
   output logic [NUM_CS-1:0]             cs_o,
   output logic                          mosi_o,
   input  logic                          miso_i
`ifdef SPI_LOOPBACK_EN
   ,
   input  logic                          loop_i
`endif
);

   localparam int CSW = cs_sel_w(NUM_CS);

   state_e             state_q, state_d;
   mode_t              mode_q, mode_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [NUM_CS-1:0]  cs_q, cs_d;
   logic               mosi_q, mosi_d;
   logic [WIDTH-1:0]   rx_data_q, rx_data_d;
   logic [WIDTH-1:0]   tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0]   rx_sh_q, rx_sh_d;

   logic tick_s, lead_stb_s, trail_stb_s, last_s, sck_raw_s, sample_s;

   spi_clk_gen #(
      .WIDTH (WIDTH),
      .DIV   (DIV)
   ) u_clk_gen (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .run_i       (state_q != IDLE),
      .shift_i     (state_q == SHIFT),
      .idle_lvl_i  (mode_q.ckp),
      .tick_o      (tick_s),
      .lead_stb_o  (lead_stb_s),
      .trail_stb_o (trail_stb_s),
      .last_o      (last_s),
      .sck_o       (sck_raw_s)
   );

`ifdef SPI_LOOPBACK_EN
   assign sample_s = loop_i ? mosi_q : miso_i;
`else
   assign sample_s = miso_i;
`endif

   // Next-state and datapath decode; an ENB drop overrides every other transition.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cs_d      = cs_q;
      mosi_d    = mosi_q;
      rx_data_d = rx_data_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      if ((state_q != IDLE) && !enb_i) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         cs_d    = '1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i && enb_i && (cs_sel_i < CSW'(NUM_CS))) begin
                  state_d = SETUP;
                  mode_d  = '{ckp: ckp_i, cph: cph_i};
                  busy_d  = 1'b1;
                  cs_d    = ~(NUM_CS'(1) << cs_sel_i);
                  mosi_d  = tx_data_i[WIDTH-1];
                  tx_sh_d = tx_data_i;
                  rx_sh_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
            SETUP: begin
               if (tick_s) begin
                  state_d = SHIFT;
               end else begin
                  state_d = SETUP;
               end
            end
            SHIFT: begin
               if (lead_stb_s) begin
                  if (!mode_q.cph) begin
                     rx_sh_d = {rx_sh_q[WIDTH-2:0], sample_s};
                  end else begin
                     mosi_d  = tx_sh_q[WIDTH-1];
                     tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                  end
               end else if (trail_stb_s) begin
                  if (!mode_q.cph) begin
                     mosi_d  = tx_sh_q[WIDTH-2];
                     tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                  end else begin
                     rx_sh_d = {rx_sh_q[WIDTH-2:0], sample_s};
                  end
                  if (last_s) begin
                     state_d = HOLD;
                  end else begin
                     state_d = SHIFT;
                  end
               end else begin
                  state_d = SHIFT;
               end
            end
            HOLD: begin
               if (tick_s) begin
                  state_d   = IDLE;
                  busy_d    = 1'b0;
                  cs_d      = '1;
                  done_d    = 1'b1;
                  rx_data_d = rx_sh_q;
               end else begin
                  state_d = HOLD;
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
               cs_d    = '1;
            end
         endcase
      end
   end

   // Controller state and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         mode_q    <= '{ckp: 1'b0, cph: 1'b0};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_q      <= '1;
         mosi_q    <= 1'b0;
         rx_data_q <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cs_q      <= cs_d;
         mosi_q    <= mosi_d;
         rx_data_q <= rx_data_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
      end
   end

   // Idle SCK follows the live CKP pin; during a transfer it follows the latched mode.
   assign sck_o     = (state_q == SHIFT) ? sck_raw_s :
                      (state_q == IDLE)  ? ckp_i     : mode_q.ckp;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign cs_o      = cs_q;
   assign mosi_o    = mosi_q;
   assign rx_data_o = rx_data_q;

endmodule
